// File: rtl/superio_host_regs.sv
// superio_host_regs
//   Host-side register block sitting in front of the SuperIO ISA bus
//   sequencer. An Avalon-MM slave (readLatency 1) stages an ISA address,
//   one byte of write data and a read/write request. The request bits are
//   driven to the sequencer, whose active-low strobes copy the staged
//   values onto the ISA drivers, capture read data and end the
//   transaction. A watchdog aborts requests the sequencer never completes.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   avs_*                 Avalon-MM slave: 0 CONTROL, 1 ADDRESS, 2 WDATA,
//                         3 STATUS {timeout, done, busy, read_data[7:0]}
//   control_out           sequencer control_in (bit0 read, bit1 write)
//   address_load, data_load, data_read, control_reset
//                         active-low sequencer strobes
//   isa_addr, isa_data_out, isa_data_oe, isa_data_in
//                         ISA bus address/data drive and data sample
module superio_host_regs #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            avs_address,
    input  logic                  avs_write,
    input  logic                  avs_read,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic [7:0]            control_out,
    input  logic                  address_load,
    input  logic                  data_load,
    input  logic                  data_read,
    input  logic                  control_reset,
    output logic [ADDR_WIDTH-1:0] isa_addr,
    output logic [7:0]            isa_data_out,
    output logic                  isa_data_oe,
    input  logic [7:0]            isa_data_in
);

    localparam logic [1:0]  REG_CONTROL = 2'd0;
    localparam logic [1:0]  REG_ADDRESS = 2'd1;
    localparam logic [1:0]  REG_WDATA   = 2'd2;
    localparam logic [1:0]  REG_STATUS  = 2'd3;
    localparam logic [15:0] WDOG_LAST   = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]            req_q, req_d;
    logic [ADDR_WIDTH-1:0] staged_addr_q, staged_addr_d;
    logic [7:0]            staged_wdata_q, staged_wdata_d;
    logic [7:0]            read_data_q, read_data_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           wdog_q, wdog_d;
    logic [ADDR_WIDTH-1:0] isa_addr_q, isa_addr_d;
    logic [7:0]            isa_data_out_q, isa_data_out_d;
    logic                  isa_data_oe_q, isa_data_oe_d;
    logic [31:0]           readdata_q, readdata_d;

    logic busy;
    logic wdog_expired;

    assign busy         = |req_q;
    assign wdog_expired = busy && (wdog_q == WDOG_LAST);

    always_comb begin
        req_d          = req_q;
        staged_addr_d  = staged_addr_q;
        staged_wdata_d = staged_wdata_q;
        read_data_d    = read_data_q;
        done_d         = done_q;
        timeout_d      = timeout_q;
        wdog_d         = wdog_q;
        isa_addr_d     = isa_addr_q;
        isa_data_out_d = isa_data_out_q;
        isa_data_oe_d  = isa_data_oe_q;
        readdata_d     = readdata_q;

        if (busy) begin
            wdog_d = wdog_q + 16'd1;
        end

        // Host register writes are locked out for the whole transaction.
        if (avs_write && !busy) begin
            case (avs_address)
                REG_ADDRESS: staged_addr_d  = avs_writedata[ADDR_WIDTH-1:0];
                REG_WDATA:   staged_wdata_d = avs_writedata[7:0];
                REG_CONTROL: begin
                    if (avs_writedata[1:0] != 2'b00) begin
                        // Read has priority when both request bits are set.
                        req_d     = avs_writedata[0] ? 2'b01 : 2'b10;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        wdog_d    = '0;
                    end
                end
                default: ;
            endcase
        end

        if (avs_read) begin
            case (avs_address)
                REG_CONTROL: readdata_d = {30'b0, req_q};
                REG_ADDRESS: readdata_d = 32'(staged_addr_q);
                REG_WDATA:   readdata_d = {24'b0, staged_wdata_q};
                default: begin
                    // Returned value shows the flags before this read clears them.
                    readdata_d = {21'b0, timeout_q, done_q, busy, read_data_q};
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            endcase
        end

        if (!address_load) begin
            isa_addr_d = staged_addr_q;
        end
        if (!data_load) begin
            isa_data_out_d = staged_wdata_q;
            isa_data_oe_d  = 1'b1;
        end
        if (!data_read) begin
            read_data_d = isa_data_in;
        end

        // Completion is evaluated last so it overrides both the watchdog
        // abort and a same-cycle STATUS clear of done.
        if (wdog_expired) begin
            req_d         = 2'b00;
            isa_data_oe_d = 1'b0;
            timeout_d     = 1'b1;
            wdog_d        = '0;
        end
        if (!control_reset) begin
            req_d         = 2'b00;
            isa_data_oe_d = 1'b0;
            done_d        = 1'b1;
            timeout_d     = timeout_q & ~wdog_expired;
            wdog_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q          <= '0;
            staged_addr_q  <= '0;
            staged_wdata_q <= '0;
            read_data_q    <= '0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            wdog_q         <= '0;
            isa_addr_q     <= '0;
            isa_data_out_q <= '0;
            isa_data_oe_q  <= 1'b0;
            readdata_q     <= '0;
        end else begin
            req_q          <= req_d;
            staged_addr_q  <= staged_addr_d;
            staged_wdata_q <= staged_wdata_d;
            read_data_q    <= read_data_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            wdog_q         <= wdog_d;
            isa_addr_q     <= isa_addr_d;
            isa_data_out_q <= isa_data_out_d;
            isa_data_oe_q  <= isa_data_oe_d;
            readdata_q     <= readdata_d;
        end
    end

    assign control_out  = {6'b0, req_q};
    assign isa_addr     = isa_addr_q;
    assign isa_data_out = isa_data_out_q;
    assign isa_data_oe  = isa_data_oe_q;
    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_superio_host_regs.sv
module tb_superio_host_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [7:0]  control_out;
    logic        address_load = 1'b1;
    logic        data_load = 1'b1;
    logic        data_read = 1'b1;
    logic        control_reset = 1'b1;
    logic [15:0] isa_addr;
    logic [7:0]  isa_data_out;
    logic        isa_data_oe;
    logic [7:0]  isa_data_in = '0;

    int n_compared = 0;
    int n_mismatched = 0;
    logic [31:0] rdata;

    superio_host_regs #(.TIMEOUT_CYCLES(64), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .control_out(control_out),
        .address_load(address_load), .data_load(data_load),
        .data_read(data_read), .control_reset(control_reset),
        .isa_addr(isa_addr), .isa_data_out(isa_data_out),
        .isa_data_oe(isa_data_oe), .isa_data_in(isa_data_in)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    // which: 0 address_load, 1 data_load, 2 data_read, 3 control_reset
    task automatic strobe(input int which);
        case (which)
            0: address_load = 1'b0;
            1: data_load = 1'b0;
            2: data_read = 1'b0;
            default: control_reset = 1'b0;
        endcase
        @(negedge clk);
        address_load = 1'b1; data_load = 1'b1; data_read = 1'b1; control_reset = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        check_val("rst_readdata", avs_readdata, 32'h0);
        check_val("rst_ctrl", {24'b0, control_out}, 32'h0);
        check_val("rst_oe", {31'b0, isa_data_oe}, 32'h0);
        avs_rd(2'd3, rdata);
        check_val("rst_status", rdata, 32'h0);

        // ISA write transaction
        avs_wr(2'd1, 32'h0000_0388);
        avs_wr(2'd2, 32'h0000_00A5);
        avs_wr(2'd0, 32'h2);
        check_val("wr_ctrl", {24'b0, control_out}, 32'h02);
        strobe(0);
        check_val("wr_isa_addr", {16'b0, isa_addr}, 32'h0388);
        strobe(1);
        check_val("wr_isa_data", {24'b0, isa_data_out}, 32'hA5);
        check_val("wr_oe_on", {31'b0, isa_data_oe}, 32'h1);
        check_val("wr_ctrl_held", {24'b0, control_out}, 32'h02);
        avs_rd(2'd3, rdata);
        check_val("wr_status_busy", rdata, 32'h100);
        strobe(3);
        check_val("wr_ctrl_done", {24'b0, control_out}, 32'h0);
        check_val("wr_oe_off", {31'b0, isa_data_oe}, 32'h0);
        avs_rd(2'd3, rdata);
        check_val("wr_status_done", rdata, 32'h200);
        avs_rd(2'd3, rdata);
        check_val("wr_status_clr", rdata, 32'h0);

        // ISA read transaction, both request bits set -> read
        avs_wr(2'd1, 32'h0000_0220);
        avs_wr(2'd0, 32'h3);
        check_val("rd_ctrl", {24'b0, control_out}, 32'h01);
        // writes while busy are dropped
        avs_wr(2'd1, 32'h0000_1234);
        avs_wr(2'd0, 32'h2);
        check_val("busy_ctrl", {24'b0, control_out}, 32'h01);
        avs_rd(2'd1, rdata);
        check_val("busy_addr", rdata, 32'h0220);
        avs_rd(2'd0, rdata);
        check_val("busy_ctrl_rd", rdata, 32'h1);
        isa_data_in = 8'h5C;
        strobe(0);
        check_val("rd_isa_addr", {16'b0, isa_addr}, 32'h0220);
        strobe(2);
        strobe(3);
        avs_rd(2'd3, rdata);
        check_val("rd_status", rdata, 32'h25C);
        avs_rd(2'd3, rdata);
        check_val("rd_status_clr", rdata, 32'h05C);
        avs_rd(2'd2, rdata);
        check_val("wdata_rd", rdata, 32'hA5);

        // Watchdog: abort exactly 64 cycles after the request edge
        do_reset();
        avs_wr(2'd0, 32'h1);
        for (int i = 1; i < 64; i++) @(negedge clk);
        check_val("wdog_63", {24'b0, control_out}, 32'h01);
        @(negedge clk);
        check_val("wdog_64", {24'b0, control_out}, 32'h0);
        avs_rd(2'd3, rdata);
        check_val("wdog_status", rdata, 32'h400);
        avs_rd(2'd3, rdata);
        check_val("wdog_status_clr", rdata, 32'h0);

        // control_reset together with CONTROL write while busy
        avs_wr(2'd0, 32'h2);
        control_reset = 1'b0;
        avs_wr(2'd0, 32'h1);
        control_reset = 1'b1;
        check_val("coll_ctrl", {24'b0, control_out}, 32'h0);
        avs_rd(2'd3, rdata);
        check_val("coll_status", rdata, 32'h200);

        // STATUS read together with control_reset: done survives
        avs_wr(2'd0, 32'h1);
        control_reset = 1'b0;
        avs_rd(2'd3, rdata);
        control_reset = 1'b1;
        check_val("rdcoll_ret", rdata, 32'h100);
        avs_rd(2'd3, rdata);
        check_val("rdcoll_done", rdata, 32'h200);

        // Reset mid write transaction, checked before the next rising edge
        avs_wr(2'd1, 32'h0000_BEEF);
        avs_wr(2'd2, 32'h0000_0033);
        avs_wr(2'd0, 32'h2);
        strobe(0);
        strobe(1);
        avs_rd(2'd1, rdata);
        check_val("pre_rst_addr", rdata, 32'hBEEF);
        #1 reset = 1'b0;
        #1;
        check_val("arst_ctrl_oe", {23'b0, isa_data_oe, control_out}, 32'h0);
        check_val("arst_isa", {isa_data_out, isa_addr}, 32'h0);
        check_val("arst_readdata", avs_readdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
